// File: rtl/fp16_accum_seq.sv
// Sequential FP16 accumulator: launches acc + element into an external combinational
// adder, captures its sum and class flags after ADD_LAT cycles, reports on the last element.
module fp16_accum_seq #(
    parameter int ADD_LAT = 1,
    parameter int CNT_W   = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [15:0]      in_data,
    input  logic             in_last,
    output logic [15:0]      add_a,
    output logic [15:0]      add_b,
    input  logic [15:0]      add_s,
    input  logic             add_snan,
    input  logic             add_qnan,
    input  logic             add_inf,
    input  logic             add_zero,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [15:0]      out_sum,
    output logic [CNT_W-1:0] out_count,
    output logic [2:0]       out_flags,
    output logic             out_zero
);

    // Handshakes: a transfer happens on a rising edge where valid and ready are both high;
    // ready/valid are decoded from registered state only, never from the partner's signal.
    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ACCEPT = 2'd1;
    localparam logic [1:0] S_WAIT   = 2'd2;
    localparam logic [1:0] S_DONE   = 2'd3;

    localparam logic [3:0]       LAT_M1  = 4'(ADD_LAT - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [1:0]       state;
    logic [3:0]       wait_cnt;
    logic             last_q;
    logic [15:0]      acc;
    logic [CNT_W-1:0] count;
    logic [2:0]       flags;
    logic             zero_q;

    assign in_ready  = (state == S_ACCEPT);
    assign out_valid = (state == S_DONE);
    assign out_sum   = acc;
    assign out_count = count;
    assign out_flags = flags;
    assign out_zero  = zero_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_IDLE;
            wait_cnt <= '0;
            last_q   <= 1'b0;
            acc      <= 16'h0000;
            add_a    <= 16'h0000;
            add_b    <= 16'h0000;
            count    <= '0;
            flags    <= 3'b000;
            zero_q   <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        acc    <= 16'h0000;
                        count  <= '0;
                        flags  <= 3'b000;
                        zero_q <= 1'b0;
                        state  <= S_ACCEPT;
                    end
                end
                S_ACCEPT: begin
                    if (in_valid) begin
                        add_a    <= acc;
                        add_b    <= in_data;
                        last_q   <= in_last;
                        wait_cnt <= LAT_M1;
                        state    <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    // Sum is taken verbatim from the adder once it has settled.
                    if (wait_cnt == 4'd0) begin
                        acc    <= add_s;
                        flags  <= flags | {add_snan, add_qnan, add_inf};
                        zero_q <= add_zero;
                        if (count != CNT_MAX) begin
                            count <= count + 1'b1;
                        end
                        state <= last_q ? S_DONE : S_ACCEPT;
                    end else begin
                        wait_cnt <= wait_cnt - 4'd1;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: doc/fp16_accum_seq.md
Name: fp16_accum_seq

Overview:
- Sequential accumulation controller for IEEE-754 binary16 values.
- Accepts a stream of FP16 operands over a valid/ready handshake and feeds the team's combinational FP16 add/sub unit: accumulator on operand A, incoming value on operand B.
- Captures the sum and class flags back into the accumulator after a fixed settle latency.
- On the element tagged last, presents the final sum, element count and sticky exception flags over an output handshake.

Parameters:
ADD_LAT, 1, cycles between operand launch and result capture; legal range 1..15.
CNT_W, 8, width of the element counter.

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  asynchronous, active-high reset
start  in  1  single-cycle pulse; clears the accumulator and opens a new sequence
in_valid  in  1  input element valid
in_ready  out  1  block can accept an element
in_data  in  16  FP16 element
in_last  in  1  element is the final one of the sequence
add_a  out  16  adder operand A (registered)
add_b  out  16  adder operand B (registered)
add_s  in  16  adder sum
add_snan  in  1  adder snan flag
add_qnan  in  1  adder qnan flag
add_inf  in  1  adder infinity flag
add_zero  in  1  adder zero flag
out_valid  out  1  result valid
out_ready  in  1  consumer accepts result
out_sum  out  16  final accumulator value
out_count  out  CNT_W  elements accumulated, saturating
out_flags  out  3  sticky {snan, qnan, inf} over the sequence
out_zero  out  1  add_zero captured on the last element

Behaviour:
- Reset (asynchronous, any state):
  - State goes to IDLE.
  - acc, add_a, add_b, out_sum = 16'h0000.
  - count = 0, flags = 0, out_zero = 0.
  - in_ready = 0, out_valid = 0.
  - Any in-flight element is discarded.
- States: IDLE, ACCEPT, WAIT, DONE. in_ready is high only in ACCEPT. out_valid is high only in DONE. Both are decoded from registered state.
- IDLE:
  - start=1 clears acc, count, flags and out_zero, then moves to ACCEPT.
  - in_valid is ignored.
- ACCEPT:
  - When in_valid & in_ready at edge T:
    - add_a <= acc, add_b <= in_data.
    - Latch in_last.
    - Load wait counter with ADD_LAT-1.
    - Move to WAIT.
  - Operands are stable from cycle T+1.
- WAIT:
  - Counter decrements each cycle.
  - On the cycle the counter reads 0 (cycle T+ADD_LAT), at the closing edge:
    - acc <= add_s.
    - flags <= flags | {add_snan, add_qnan, add_inf}.
    - count <= count+1, saturating at 2^CNT_W-1.
    - out_zero <= add_zero.
  - Then go to DONE if the latched last is set, otherwise ACCEPT.
  - Throughput is one element per ADD_LAT+1 cycles. With ADD_LAT=1: handshake at T, capture at the end of T+1, in_ready high again at T+2.
- DONE:
  - out_sum = acc; out_count and out_flags hold.
  - Hold until out_ready=1, then go to IDLE.
  - out_valid drops the cycle after acceptance.
  - Outputs stay stable while out_ready=0.
- start in any state other than IDLE is ignored.
  - start coincident with the DONE acceptance edge is also ignored; a new start is needed in IDLE.
- add_a and add_b hold their last values outside WAIT; they are never cleared except by rst.
- Arithmetic:
  - No rounding, re-normalisation or NaN canonicalisation; add_s is stored verbatim.
  - The first element is always added to +0 (16'h0000).
- in_last on the very first element gives count=1 and sum = 0 + x.
- Element count wraps never; it saturates.

Test Plan:
- rst; start; elements 3C00, 3C00(last); out_ready=1 -> out_sum=4000, out_count=2, out_flags=000, out_zero=0, out_valid high for exactly 1 cycle.
- start; elements 3C00, BC00(last) -> out_sum=0000, out_zero=1, out_count=2, out_flags=000.
- start; 7C00, 7C00(last) -> out_sum=7C00, out_flags=001. Then start; 7C00, FC00(last) -> out_sum=7E00, out_flags=010 (sticky does not carry across start).
- ADD_LAT=3; in_valid held high with 3C00, 4000, 4200(last) -> handshakes exactly 4 cycles apart; out_sum=4600, out_count=3; add_a/add_b change only on the cycle after each handshake.
- DONE with out_ready=0 for 5 cycles while start and in_valid toggle -> out_valid, out_sum and out_count stable, in_ready=0; out_ready=1 -> IDLE the next cycle.
- rst asserted mid-WAIT (not clock-aligned) -> in_ready, out_valid and acc go to 0 immediately. A following sequence 4000(last) gives out_sum=4000, out_count=1.
